// File: rtl/kart_physics_pkg.sv
// Shared codes and helpers for the kart physics engine.
// Game-state/operation encodings, step FSM encoding and the Q1.6 cosine table.
package kart_physics_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SETTING   = 3'd1;
  localparam logic [2:0] ST_COUNTDOWN = 3'd3;
  localparam logic [2:0] ST_RACING    = 3'd4;
  localparam logic [2:0] ST_PAUSE     = 3'd5;
  localparam logic [2:0] ST_FINISH    = 3'd6;

  localparam logic [2:0] OP_NIL      = 3'd0;
  localparam logic [2:0] OP_FORWARD  = 3'd1;
  localparam logic [2:0] OP_BACKWARD = 3'd2;
  localparam logic [2:0] OP_LEFT     = 3'd3;
  localparam logic [2:0] OP_RIGHT    = 3'd4;

  localparam int LUT_SCALE_SHIFT = 6;

  typedef enum logic [1:0] {
    P_IDLE  = 2'd0,
    P_VEL   = 2'd1,
    P_MOVE  = 2'd2,
    P_CLAMP = 2'd3
  } phys_state_t;

  typedef logic signed [7:0] trig_t;

  // 16 headings of 22.5 deg, +-64 = +-1.0; sine is the same table shifted by a quarter turn.
  function automatic trig_t cos_q6(input logic [3:0] idx);
    case (idx)
      4'd0:    cos_q6 =  8'sd64;
      4'd1:    cos_q6 =  8'sd59;
      4'd2:    cos_q6 =  8'sd45;
      4'd3:    cos_q6 =  8'sd24;
      4'd4:    cos_q6 =  8'sd0;
      4'd5:    cos_q6 = -8'sd24;
      4'd6:    cos_q6 = -8'sd45;
      4'd7:    cos_q6 = -8'sd59;
      4'd8:    cos_q6 = -8'sd64;
      4'd9:    cos_q6 = -8'sd59;
      4'd10:   cos_q6 = -8'sd45;
      4'd11:   cos_q6 = -8'sd24;
      4'd12:   cos_q6 =  8'sd0;
      4'd13:   cos_q6 =  8'sd24;
      4'd14:   cos_q6 =  8'sd45;
      4'd15:   cos_q6 =  8'sd59;
      default: cos_q6 =  8'sd0;
    endcase
  endfunction

endpackage

// File: rtl/heading_trig_lut.sv
// Combinational heading -> (sin, cos) lookup in signed Q1.6.
// Heading 0 points along +x; headings advance clockwise with screen y pointing down.
module heading_trig_lut
  import kart_physics_pkg::*;
#(
  parameter int ANGLE_W = 4
) (
  input  logic [ANGLE_W-1:0] angle,
  output trig_t              sin_val,
  output trig_t              cos_val
);

  logic [3:0] idx_s;

  if (ANGLE_W >= 4) begin : g_idx_trunc
    assign idx_s = angle[ANGLE_W-1 -: 4];
  end else begin : g_idx_pad
    assign idx_s = {angle, {(4-ANGLE_W){1'b0}}};
  end

  // sin(a) = cos(a - 90 deg), i.e. four table steps back
  always_comb begin
    cos_val = cos_q6(idx_s);
    sin_val = cos_q6(idx_s - 4'd4);
  end

endmodule

// File: rtl/kart_physics_engine.sv
// Per-kart motion integrator: one physics step (velocity, move, clamp) per accepted frame tick.
// Optional boost meter enabled by defining BOOST_METER_EN.
module kart_physics_engine
  import kart_physics_pkg::*;
#(
  parameter int POS_W            = 10,
  parameter int FRAC_W           = 4,
  parameter int SPEED_W          = 8,
  parameter int ANGLE_W          = 4,
  parameter int MAP_MAX_X        = 320,
  parameter int MAP_MAX_Y        = 240,
  parameter int START_X          = 0,
  parameter int START_Y          = 0,
  parameter int START_ANGLE      = 0,
  parameter int ACCEL            = 5,
  parameter int BRAKE            = 8,
  parameter int FRICTION         = 2,
  parameter int BOOST_ACCEL      = 20,
  parameter int MAX_SPEED        = 64,
  parameter int BOOST_MAX_SPEED  = 128,
  parameter int BOOST_CAP        = 255,
  parameter int BOOST_REFILL_DIV = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [2:0]         state,
  input  logic [2:0]         operation_code,
  input  logic               boost,
  output logic [POS_W-1:0]   pos_x,
  output logic [POS_W-1:0]   pos_y,
  output logic [ANGLE_W-1:0] angle,
  output logic [SPEED_W-1:0] speed,
  output logic               busy,
  output logic               upd_valid,
  output logic               hit_wall,
  output logic [7:0]         boost_level
);

  localparam int PFW  = POS_W + FRAC_W;
  localparam int SW1  = SPEED_W + 1;
  localparam int PRW  = SW1 + 8;
  localparam int SUMW = PFW + PRW;
  localparam logic [PFW-1:0]         START_X_FX = PFW'(START_X << FRAC_W);
  localparam logic [PFW-1:0]         START_Y_FX = PFW'(START_Y << FRAC_W);
  localparam logic signed [SUMW-1:0] MAX_X_SUM  = SUMW'((MAP_MAX_X - 1) << FRAC_W);
  localparam logic signed [SUMW-1:0] MAX_Y_SUM  = SUMW'((MAP_MAX_Y - 1) << FRAC_W);
  localparam logic [ANGLE_W-1:0]     ANG_ONE    = ANGLE_W'(1);

  phys_state_t p_state_r, p_next_s;
  logic accept_s, vel_en_s, move_en_s, clamp_en_s;

  logic [2:0]                lat_state_r, lat_op_r;
  logic                      lat_boost_r, eff_boost_s;
  logic [PFW-1:0]            x_fx_r, y_fx_r, nx_s, ny_s;
  logic [ANGLE_W-1:0]        ang_r, ang_next_s;
  logic [SPEED_W-1:0]        spd_r;
  logic [SW1-1:0]            spd_ext_s, cap_s, fric_s, decay_s, base_s, spd_next_s;
  logic signed [PRW-1:0]     prod_x_s, prod_y_s, dx_r, dy_r;
  logic signed [SUMW-1:0]    sum_x_s, sum_y_s;
  logic                      hx_s, hy_s, hit_r, publish_r;
  trig_t                     sin_s, cos_s;

  heading_trig_lut #(.ANGLE_W(ANGLE_W)) u_trig (
    .angle   (ang_r),
    .sin_val (sin_s),
    .cos_val (cos_s)
  );

`ifdef BOOST_METER_EN
  logic [7:0] meter_r, refill_cnt_r;
  assign eff_boost_s = lat_boost_r && (meter_r != 8'd0);
`else
  logic [7:0] cfg_unused_s;
  assign eff_boost_s  = lat_boost_r;
  assign cfg_unused_s = 8'(BOOST_CAP) ^ 8'(BOOST_REFILL_DIV);
`endif

  // Step FSM state register
  always_ff @(posedge clk) begin
    if (!rst) p_state_r <= P_IDLE;
    else      p_state_r <= p_next_s;
  end

  // Step FSM next state; ticks outside P_IDLE are ignored
  always_comb begin
    p_next_s = p_state_r;
    case (p_state_r)
      P_IDLE:  if (tick) p_next_s = P_VEL; else p_next_s = P_IDLE;
      P_VEL:   p_next_s = P_MOVE;
      P_MOVE:  p_next_s = P_CLAMP;
      P_CLAMP: p_next_s = P_IDLE;
      default: p_next_s = P_IDLE;
    endcase
  end

  // Step FSM stage enables
  always_comb begin
    accept_s   = 1'b0;
    vel_en_s   = 1'b0;
    move_en_s  = 1'b0;
    clamp_en_s = 1'b0;
    case (p_state_r)
      P_IDLE:  accept_s   = tick;
      P_VEL:   vel_en_s   = 1'b1;
      P_MOVE:  move_en_s  = 1'b1;
      P_CLAMP: clamp_en_s = 1'b1;
      default: accept_s   = 1'b0;
    endcase
  end

  // Velocity stage: new speed and heading from the latched command
  always_comb begin
    spd_ext_s  = {1'b0, spd_r};
    cap_s      = eff_boost_s ? SW1'(BOOST_MAX_SPEED) : SW1'(MAX_SPEED);
    fric_s     = (spd_ext_s > SW1'(FRICTION)) ? spd_ext_s - SW1'(FRICTION) : {SW1{1'b0}};
    decay_s    = (fric_s < cap_s) ? cap_s : fric_s;
    base_s     = spd_ext_s;
    ang_next_s = ang_r;
    spd_next_s = spd_ext_s;
    case (lat_state_r)
      ST_RACING: begin
        case (lat_op_r)
          OP_FORWARD:  base_s = spd_ext_s + (eff_boost_s ? SW1'(BOOST_ACCEL) : SW1'(ACCEL));
          OP_BACKWARD: base_s = (spd_ext_s > SW1'(BRAKE)) ? spd_ext_s - SW1'(BRAKE) : {SW1{1'b0}};
          OP_LEFT:     ang_next_s = ang_r - ANG_ONE;
          OP_RIGHT:    ang_next_s = ang_r + ANG_ONE;
          OP_NIL:      base_s = fric_s;
          default:     base_s = spd_ext_s;
        endcase
        // above the cap (boost just ended) bleed off by friction, but let the brake bite harder
        if (spd_ext_s > cap_s) begin
          spd_next_s = (base_s < decay_s) ? base_s : decay_s;
        end else begin
          spd_next_s = (base_s > cap_s) ? cap_s : base_s;
        end
      end
      ST_IDLE, ST_SETTING: begin
        spd_next_s = {SW1{1'b0}};
        ang_next_s = ANGLE_W'(START_ANGLE);
      end
      ST_COUNTDOWN, ST_FINISH: spd_next_s = {SW1{1'b0}};
      default: spd_next_s = spd_ext_s;
    endcase
  end

  assign prod_x_s = PRW'($signed(spd_ext_s)) * PRW'(cos_s);
  assign prod_y_s = PRW'($signed(spd_ext_s)) * PRW'(sin_s);
  assign sum_x_s  = $signed({{(SUMW-PFW){1'b0}}, x_fx_r}) + SUMW'(dx_r);
  assign sum_y_s  = $signed({{(SUMW-PFW){1'b0}}, y_fx_r}) + SUMW'(dy_r);

  // Clamp stage: keep both axes inside the map
  always_comb begin
    hx_s = 1'b0;
    hy_s = 1'b0;
    if (sum_x_s[SUMW-1]) begin
      nx_s = {PFW{1'b0}};
      hx_s = 1'b1;
    end else if (sum_x_s > MAX_X_SUM) begin
      nx_s = PFW'(MAX_X_SUM);
      hx_s = 1'b1;
    end else begin
      nx_s = sum_x_s[PFW-1:0];
    end
    if (sum_y_s[SUMW-1]) begin
      ny_s = {PFW{1'b0}};
      hy_s = 1'b1;
    end else if (sum_y_s > MAX_Y_SUM) begin
      ny_s = PFW'(MAX_Y_SUM);
      hy_s = 1'b1;
    end else begin
      ny_s = sum_y_s[PFW-1:0];
    end
  end

  // Physics datapath: latch, velocity, move, clamp
  always_ff @(posedge clk) begin
    if (!rst) begin
      lat_state_r <= ST_IDLE;
      lat_op_r    <= OP_NIL;
      lat_boost_r <= 1'b0;
      x_fx_r      <= START_X_FX;
      y_fx_r      <= START_Y_FX;
      ang_r       <= ANGLE_W'(START_ANGLE);
      spd_r       <= {SPEED_W{1'b0}};
      dx_r        <= {PRW{1'b0}};
      dy_r        <= {PRW{1'b0}};
      hit_r       <= 1'b0;
      publish_r   <= 1'b0;
    end else begin
      publish_r <= clamp_en_s;
      if (accept_s) begin
        lat_state_r <= state;
        lat_op_r    <= operation_code;
        lat_boost_r <= boost;
      end
      if (vel_en_s) begin
        spd_r <= spd_next_s[SPEED_W-1:0];
        ang_r <= ang_next_s;
      end
      if (move_en_s) begin
        dx_r <= prod_x_s >>> LUT_SCALE_SHIFT;
        dy_r <= prod_y_s >>> LUT_SCALE_SHIFT;
      end
      if (clamp_en_s) begin
        hit_r <= 1'b0;
        if (lat_state_r == ST_RACING) begin
          x_fx_r <= nx_s;
          y_fx_r <= ny_s;
          hit_r  <= hx_s | hy_s;
          if (hx_s | hy_s) spd_r <= {SPEED_W{1'b0}};
        end else if (lat_state_r == ST_IDLE || lat_state_r == ST_SETTING) begin
          x_fx_r <= START_X_FX;
          y_fx_r <= START_Y_FX;
        end
      end
    end
  end

`ifdef BOOST_METER_EN
  // Boost meter: drains on boosted moves, refills slowly on the other accepted ticks
  always_ff @(posedge clk) begin
    if (!rst) begin
      meter_r      <= 8'(BOOST_CAP);
      refill_cnt_r <= 8'd0;
    end else if (vel_en_s) begin
      if (lat_state_r == ST_RACING && lat_op_r != OP_NIL && lat_boost_r) begin
        if (meter_r != 8'd0) meter_r <= meter_r - 8'd1;
      end else if (refill_cnt_r >= 8'(BOOST_REFILL_DIV - 1)) begin
        refill_cnt_r <= 8'd0;
        if (meter_r < 8'(BOOST_CAP)) meter_r <= meter_r + 8'd1;
      end else begin
        refill_cnt_r <= refill_cnt_r + 8'd1;
      end
    end
  end
`endif

  // Published outputs: refreshed one cycle after the clamp stage
  always_ff @(posedge clk) begin
    if (!rst) begin
      pos_x     <= START_X_FX[PFW-1:FRAC_W];
      pos_y     <= START_Y_FX[PFW-1:FRAC_W];
      angle     <= ANGLE_W'(START_ANGLE);
      speed     <= {SPEED_W{1'b0}};
      busy      <= 1'b0;
      upd_valid <= 1'b0;
      hit_wall  <= 1'b0;
    end else begin
      busy      <= (p_next_s != P_IDLE);
      upd_valid <= publish_r;
      hit_wall  <= publish_r & hit_r;
      if (publish_r) begin
        pos_x <= x_fx_r[PFW-1:FRAC_W];
        pos_y <= y_fx_r[PFW-1:FRAC_W];
        angle <= ang_r;
        speed <= spd_r;
      end
    end
  end

`ifdef BOOST_METER_EN
  // Published boost meter
  always_ff @(posedge clk) begin
    if (!rst)           boost_level <= 8'(BOOST_CAP);
    else if (publish_r) boost_level <= meter_r;
  end
`else
  assign boost_level = 8'd0;
`endif

endmodule

// File: tb/tb_kart_physics_engine.sv
// Directed, table-driven bench for kart_physics_engine (BOOST_METER_EN selects the meter sequence).
module tb_kart_physics_engine;
  import kart_physics_pkg::*;

`ifdef BOOST_METER_EN
  localparam int BCAP    = 2;
  localparam int EXP_LVL = 2;
`else
  localparam int BCAP    = 255;
  localparam int EXP_LVL = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic [2:0] state = 3'd0;
  logic [2:0] operation_code = 3'd0;
  logic       boost = 1'b0;
  logic [9:0] pos_x, pos_y;
  logic [3:0] angle;
  logic [7:0] speed, boost_level;
  logic       busy, upd_valid, hit_wall;

  int total = 0;
  int bad = 0;

  kart_physics_engine #(.BOOST_CAP(BCAP)) dut (
    .clk(clk), .rst(rst), .tick(tick), .state(state), .operation_code(operation_code),
    .boost(boost), .pos_x(pos_x), .pos_y(pos_y), .angle(angle), .speed(speed),
    .busy(busy), .upd_valid(upd_valid), .hit_wall(hit_wall), .boost_level(boost_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic [2:0] op;
    logic       bst;
    int         ex;
    int         ey;
    int         ea;
    int         es;
    int         eh;
  } vec_t;

  vec_t tbl [22];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic [2:0] st, input logic [2:0] op, input logic b);
    int n;
    @(negedge clk);
    state = st; operation_code = op; boost = b; tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk("busy_during_step", busy, 1);
    n = 0;
    while (!upd_valid && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk("upd_latency", n, 4);
  endtask

  task automatic check_pose(input string tag, input int ex, input int ey, input int ea,
                            input int es, input int eh);
    chk({tag, ".pos_x"}, int'(pos_x), ex);
    chk({tag, ".pos_y"}, int'(pos_y), ey);
    chk({tag, ".angle"}, int'(angle), ea);
    chk({tag, ".speed"}, int'(speed), es);
    chk({tag, ".hit_wall"}, int'(hit_wall), eh);
  endtask

  initial begin
    int s, x, hits, pulses;
    int bspd [10];

    tbl[0]  = '{ST_RACING,    OP_FORWARD,  1'b0, 0, 0,  0,  5, 0};
    tbl[1]  = '{ST_RACING,    OP_FORWARD,  1'b0, 0, 0,  0, 10, 0};
    tbl[2]  = '{ST_RACING,    OP_FORWARD,  1'b0, 1, 0,  0, 15, 0};
    tbl[3]  = '{ST_RACING,    OP_RIGHT,    1'b0, 2, 0,  1, 15, 0};
    tbl[4]  = '{ST_RACING,    OP_RIGHT,    1'b0, 3, 0,  2, 15, 0};
    tbl[5]  = '{ST_RACING,    OP_LEFT,     1'b0, 4, 1,  1, 15, 0};
    tbl[6]  = '{ST_RACING,    OP_LEFT,     1'b0, 5, 1,  0, 15, 0};
    tbl[7]  = '{ST_RACING,    OP_LEFT,     1'b0, 5, 0, 15, 15, 0};
    tbl[8]  = '{ST_RACING,    OP_RIGHT,    1'b0, 6, 0,  0, 15, 0};
    tbl[9]  = '{ST_RACING,    OP_NIL,      1'b0, 7, 0,  0, 13, 0};
    tbl[10] = '{ST_PAUSE,     OP_FORWARD,  1'b0, 7, 0,  0, 13, 0};
    tbl[11] = '{ST_RACING,    OP_BACKWARD, 1'b0, 7, 0,  0,  5, 0};
    tbl[12] = '{ST_RACING,    OP_BACKWARD, 1'b0, 7, 0,  0,  0, 0};
    tbl[13] = '{ST_RACING,    OP_FORWARD,  1'b0, 8, 0,  0,  5, 0};
    tbl[14] = '{ST_FINISH,    OP_FORWARD,  1'b0, 8, 0,  0,  0, 0};
    tbl[15] = '{ST_RACING,    OP_FORWARD,  1'b0, 8, 0,  0,  5, 0};
    tbl[16] = '{ST_RACING,    OP_LEFT,     1'b0, 8, 0, 15,  5, 0};
    tbl[17] = '{ST_RACING,    OP_LEFT,     1'b0, 9, 0, 14,  5, 0};
    tbl[18] = '{ST_RACING,    OP_LEFT,     1'b0, 9, 0, 13,  5, 0};
    tbl[19] = '{ST_RACING,    OP_LEFT,     1'b0, 9, 0, 12,  0, 1};
    tbl[20] = '{ST_COUNTDOWN, OP_FORWARD,  1'b0, 9, 0, 12,  0, 0};
    tbl[21] = '{ST_SETTING,   OP_FORWARD,  1'b0, 0, 0,  0,  0, 0};

    // reset state
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_pose("reset", 0, 0, 0, 0, 0);
    chk("reset.busy", busy, 0);
    chk("reset.upd_valid", upd_valid, 0);
    chk("reset.boost_level", int'(boost_level), EXP_LVL);

`ifdef BOOST_METER_EN
    // meter of 2: two boosted accelerations then a plain one; NIL ticks refill
    step(ST_RACING, OP_FORWARD, 1'b1);
    chk("meter1.speed", speed, 20); chk("meter1.level", boost_level, 1);
    step(ST_RACING, OP_FORWARD, 1'b1);
    chk("meter2.speed", speed, 40); chk("meter2.level", boost_level, 0);
    step(ST_RACING, OP_FORWARD, 1'b1);
    chk("meter3.speed", speed, 45); chk("meter3.level", boost_level, 0);
    for (int i = 0; i < 4; i++) begin
      step(ST_RACING, OP_NIL, 1'b0);
      chk("meter_nil.speed", speed, 43 - 2 * i);
      chk("meter_nil.level", boost_level, (i == 3) ? 1 : 0);
    end
    step(ST_SETTING, OP_NIL, 1'b0);
    check_pose("meter_respawn", 0, 0, 0, 0, 0);
`endif

    // main directed table
    for (int i = 0; i < 22; i++) begin
      step(tbl[i].st, tbl[i].op, tbl[i].bst);
      check_pose($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].ea, tbl[i].es, tbl[i].eh);
    end

    // drive into the right wall, then push against it once more
    s = 0; x = 0; hits = 0;
    for (int k = 0; k < 100 && hits < 2; k++) begin
      int h;
      s = (s + 5 > 64) ? 64 : s + 5;
      x = x + s;
      h = 0;
      if (x > 319 * 16) begin
        x = 319 * 16; h = 1; s = 0; hits++;
      end
      step(ST_RACING, OP_FORWARD, 1'b0);
      chk("wall.pos_x", int'(pos_x), x / 16);
      chk("wall.speed", int'(speed), s);
      chk("wall.hit_wall", int'(hit_wall), h);
    end
    chk("wall.hits_seen", hits, 2);
    chk("wall.final_x", int'(pos_x), 319);

    // tick during a busy step is dropped
    step(ST_SETTING, OP_NIL, 1'b0);
    @(negedge clk);
    state = ST_RACING; operation_code = OP_FORWARD; boost = 1'b0; tick = 1'b1;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      if (upd_valid) pulses++;
      @(negedge clk);
    end
    chk("drop.pulses", pulses, 1);
    chk("drop.speed", int'(speed), 5);
    chk("drop.pos_x", int'(pos_x), 0);

`ifndef BOOST_METER_EN
    // boost up to the boosted cap, then bleed off after release
    step(ST_SETTING, OP_NIL, 1'b0);
    bspd = '{20, 40, 60, 80, 100, 120, 128, 126, 124, 122};
    for (int i = 0; i < 10; i++) begin
      if (i < 7)       step(ST_RACING, OP_FORWARD, 1'b1);
      else if (i < 9)  step(ST_RACING, OP_NIL, 1'b0);
      else             step(ST_RACING, OP_FORWARD, 1'b0);
      chk($sformatf("boost%0d.speed", i), int'(speed), bspd[i]);
    end
`endif

    // reset in the middle of a step
    @(negedge clk);
    state = ST_RACING; operation_code = OP_FORWARD; boost = 1'b0; tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_pose("midreset", 0, 0, 0, 0, 0);
    chk("midreset.busy", busy, 0);
    chk("midreset.boost_level", int'(boost_level), EXP_LVL);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (upd_valid) pulses++;
      @(negedge clk);
    end
    chk("midreset.no_update", pulses, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
